// File: rtl/conv_8x32_zreader.sv
// rtl/conv_8x32_zreader.sv - Z-port result capture buffer with in-order valid/ready readout
module conv_8x32_zreader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  writeZ_i,
    input  logic [ADDR_WIDTH-1:0] memZ_addr_i,
    input  logic [DATA_WIDTH-1:0] dataZ_i,
    input  logic                  done_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_last_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  drained_o,
    output logic                  capturing_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic                  drained_q, drained_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_len;
    logic                  at_last;
    logic                  xfer;

    // Length implied by this write; count only ever grows to the highest address seen.
    assign wr_len  = {1'b0, memZ_addr_i} + ONE;
    assign at_last = ({1'b0, ptr_q} == (count_q - ONE));
    assign xfer    = rd_valid_o & rd_ready_i;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        drained_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CAPTURE;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (writeZ_i) begin
                    err_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (writeZ_i) begin
                    mem_we = 1'b1;
                    if (wr_len > count_q) count_d = wr_len;
                end
                // count_d already includes a write landing in the same cycle as done
                if (done_i) begin
                    if (count_d != '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d   = IDLE;
                        drained_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (writeZ_i || start_i) err_d = 1'b1;
                if (xfer) begin
                    if (at_last) begin
                        state_d   = IDLE;
                        ptr_d     = '0;
                        drained_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            drained_q <= drained_d;
        end
    end

    // Result buffer is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[memZ_addr_i] <= dataZ_i;
    end

    assign rd_valid_o  = (state_q == DRAIN);
    assign rd_data_o   = rd_valid_o ? mem[ptr_q] : '0;
    assign rd_addr_o   = rd_valid_o ? ptr_q : '0;
    assign rd_last_o   = rd_valid_o & at_last;
    assign count_o     = count_q;
    assign drained_o   = drained_q;
    assign capturing_o = (state_q == CAPTURE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_conv_8x32_zreader.sv
// tb/tb_conv_8x32_zreader.sv - scoreboard bench for conv_8x32_zreader
module tb_conv_8x32_zreader;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start_i, writeZ_i, done_i, rd_ready_i;
    logic [AW-1:0] memZ_addr_i;
    logic [DW-1:0] dataZ_i;
    logic          rd_valid_o, rd_last_o, drained_o, capturing_o, err_o;
    logic [DW-1:0] rd_data_o;
    logic [AW-1:0] rd_addr_o;
    logic [AW:0]   count_o;

    conv_8x32_zreader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .writeZ_i(writeZ_i),
        .memZ_addr_i(memZ_addr_i), .dataZ_i(dataZ_i), .done_i(done_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_last_o(rd_last_o), .count_o(count_o),
        .drained_o(drained_o), .capturing_o(capturing_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: buffer image, result length, and the queue of beats the host must see
    logic [DW-1:0] sb_mem [64];
    int            sb_count;
    int            exp_addr [$];
    logic [DW-1:0] exp_data [$];
    logic [DW-1:0] got [$];

    bit            chk_en = 0;
    int            drained_cnt = 0;
    bit            prev_drained = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            if (drained_o) begin
                drained_cnt++;
                chk("drained_single_cycle", prev_drained, 0);
            end
            prev_drained = drained_o;
            if (rd_valid_o) begin
                if (prev_stall) begin
                    chk("stall_hold_data", rd_data_o, prev_data);
                    chk("stall_hold_addr", rd_addr_o, prev_addr);
                end
                if (exp_addr.size() == 0) begin
                    chk("unexpected_valid", rd_valid_o, 0);
                end else begin
                    chk("beat_addr", rd_addr_o, exp_addr[0]);
                    chk("beat_data", rd_data_o, exp_data[0]);
                    chk("beat_last", rd_last_o, exp_addr.size() == 1);
                    if (rd_ready_i) begin
                        got.push_back(rd_data_o);
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
                prev_stall = !rd_ready_i;
                prev_data  = rd_data_o;
                prev_addr  = rd_addr_o;
            end else begin
                chk("idle_data_zero", rd_data_o, 0);
                chk("idle_addr_zero", rd_addr_o, 0);
                chk("idle_last_zero", rd_last_o, 0);
                prev_stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        sb_count = 0;
        got.delete();
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        writeZ_i    = 1'b1;
        memZ_addr_i = AW'(a);
        dataZ_i     = d;
        tick();
        writeZ_i = 1'b0;
        sb_mem[a] = d;
        if (a + 1 > sb_count) sb_count = a + 1;
    endtask

    task automatic do_done();
        for (int i = 0; i < sb_count; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(sb_mem[i]);
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int base);
        for (int i = 0; i < 300; i++) begin
            if (drained_cnt > base) break;
            tick();
        end
        chk({name, "_drained"}, drained_cnt > base, 1);
        chk({name, "_all_beats"}, exp_addr.size(), 0);
    endtask

    task automatic write4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        do_write(0, d0);
        do_write(1, d1);
        do_write(2, d2);
        do_write(3, d3);
    endtask

    int base;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        rst = 1'b1; start_i = 0; writeZ_i = 0; done_i = 0; rd_ready_i = 1;
        memZ_addr_i = '0; dataZ_i = '0;
        #3;
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_capturing", capturing_o, 0);
        chk("rst_drained", drained_o, 0);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1;

        // 1: basic stream
        base = drained_cnt;
        do_start();
        chk("t1_capturing", capturing_o, 1);
        write4(16'h0006, 16'h0011, 16'h0014, 16'h0008);
        do_done();
        chk("t1_first_valid", rd_valid_o, 1);
        tick(); tick(); tick(); tick();
        chk("t1_back_to_back", got.size(), 4);
        wait_drain("t1", base);
        chk("t1_count", count_o, 4);
        chk("t1_beat0", got[0], 16'h0006);
        chk("t1_beat1", got[1], 16'h0011);
        chk("t1_beat2", got[2], 16'h0014);
        chk("t1_beat3", got[3], 16'h0008);
        chk("t1_err", err_o, 0);

        // 2: backpressure
        base = drained_cnt;
        do_start();
        write4(16'h0006, 16'h0011, 16'h0014, 16'h0008);
        do_done();
        for (int i = 0; i < 7; i++) begin
            rd_ready_i = pat[i];
            tick();
        end
        rd_ready_i = 1'b1;
        wait_drain("t2", base);
        chk("t2_transfers", got.size(), 4);
        chk("t2_beat3", got[3], 16'h0008);

        // 3: out-of-order and overwrite
        base = drained_cnt;
        do_start();
        do_write(2, 16'h00AA);
        do_write(0, 16'h0001);
        do_write(2, 16'h00BB);
        do_write(1, 16'h0002);
        do_done();
        wait_drain("t3", base);
        chk("t3_count", count_o, 3);
        chk("t3_beat0", got[0], 16'h0001);
        chk("t3_beat1", got[1], 16'h0002);
        chk("t3_beat2", got[2], 16'h00BB);

        // 4a: full buffer
        base = drained_cnt;
        do_start();
        for (int a = 0; a < 64; a++) do_write(a, DW'(a * 3));
        do_done();
        wait_drain("t4_full", base);
        chk("t4_count_full", count_o, 64);
        chk("t4_beats", got.size(), 64);
        chk("t4_beat63", got[63], 16'd189);

        // 4b: empty result
        base = drained_cnt;
        do_start();
        do_done();
        wait_drain("t4_empty", base);
        chk("t4_count_empty", count_o, 0);
        chk("t4_empty_beats", got.size(), 0);

        // 5: protocol errors
        writeZ_i = 1'b1;
        tick();
        writeZ_i = 1'b0;
        chk("t5_idle_write_err", err_o, 1);
        base = drained_cnt;
        do_start();
        chk("t5_start_clears_err", err_o, 0);
        write4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        do_done();
        writeZ_i = 1'b1; memZ_addr_i = '0; dataZ_i = 16'hFFFF;
        tick();
        writeZ_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_drain("t5", base);
        chk("t5_err_set", err_o, 1);
        chk("t5_beat0", got[0], 16'h1234);
        tick(); tick(); tick();
        chk("t5_err_held", err_o, 1);
        chk("t5_idle_after_drain", capturing_o, 0);
        base = drained_cnt;
        do_start();
        chk("t5_err_cleared", err_o, 0);
        do_done();
        wait_drain("t5_empty", base);

        // 6: reset mid-drain
        do_start();
        write4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        do_done();
        tick(); tick();
        chk_en = 0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", rd_valid_o, 0);
        chk("t6_rst_data", rd_data_o, 0);
        chk("t6_rst_addr", rd_addr_o, 0);
        chk("t6_rst_last", rd_last_o, 0);
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_capturing", capturing_o, 0);
        chk("t6_rst_drained", drained_o, 0);
        exp_addr.delete();
        exp_data.delete();
        tick();
        rst = 1'b0;
        prev_stall = 0;
        prev_drained = 0;
        chk_en = 1;
        base = drained_cnt;
        do_start();
        write4(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        do_done();
        wait_drain("t6", base);
        chk("t6_beat0", got[0], 16'h0A0A);
        chk("t6_beat3", got[3], 16'h0D0D);
        chk("t6_count", count_o, 4);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_8x32_zreader.md
Name: conv_8x32_zreader

Overview:
- Consumer end of the coprocessor's Z-result write port.
- Captures every writeZ/memZ_addr/dataZ beat of one convolution into an internal result buffer and tracks the result length.
- Once the coprocessor signals done, streams the results in address order to the host over a valid/ready interface.
- Sits beside the convolution core, between its Z port and the host bus.

Parameters:
DATA_WIDTH, 16, width of one Z result word
ADDR_WIDTH, 6, width of Z address
DEPTH, 64, buffer entries (2**ADDR_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start_i  input  1  same start pulse given to the convolution core; arms capture
writeZ_i  input  1  Z write strobe from core
memZ_addr_i  input  ADDR_WIDTH  Z write address
dataZ_i  input  DATA_WIDTH  Z write data
done_i  input  1  core done indication (level)
rd_valid_o  output  1  result word presented to host
rd_ready_i  input  1  host accepts word
rd_data_o  output  DATA_WIDTH  result word
rd_addr_o  output  ADDR_WIDTH  index of presented word
rd_last_o  output  1  presented word is the final one
count_o  output  ADDR_WIDTH+1  captured result length (0..64)
drained_o  output  1  one-cycle pulse when readout completes
capturing_o  output  1  high in CAPTURE
err_o  output  1  sticky protocol error, cleared by accepted start_i

Behaviour:
- Reset (asynchronous, any state, including mid-drain):
  - state IDLE; count, read pointer and err cleared.
  - All outputs 0.
  - Buffer contents not reset.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start_i=1 -> CAPTURE next cycle; count<=0; err<=0.
  - writeZ_i ignored and sets err.
- CAPTURE (capturing_o=1):
  - writeZ_i=1 -> mem[memZ_addr_i]<=dataZ_i; count<=max(count, memZ_addr_i+1).
  - Re-write of an address overwrites; last write wins.
  - Writes may arrive in any address order.
  - start_i ignored.
  - done_i=1 -> DRAIN if count (including a write in the same cycle) >0. Otherwise -> IDLE with drained_o pulsed, no valid.
  - A write coincident with done_i is captured before the transition.
- DRAIN:
  - rd_valid_o=1; rd_addr_o=ptr; rd_data_o=mem[ptr] (combinational read of buffer).
  - rd_last_o=(ptr==count-1).
  - Output stable while rd_valid_o & !rd_ready_i.
  - Transfer when rd_valid_o & rd_ready_i: ptr<=ptr+1.
  - On transfer with rd_last_o -> IDLE, ptr<=0, drained_o=1 that cycle+1 (registered, one cycle), rd_valid_o drops the next cycle.
  - writeZ_i or start_i in DRAIN: ignored, err<=1.
  - done_i ignored.
- Unwritten addresses below count read out whatever the buffer holds (undefined); this block does not zero-fill.
- Throughput: one word per cycle with rd_ready_i held high; first rd_valid_o the cycle after done_i is sampled in CAPTURE.
- count_o holds its value after drain until the next accepted start_i.
- rd_data_o and rd_addr_o are 0 whenever rd_valid_o=0.
- Widths: count is ADDR_WIDTH+1 so a full 64-entry result is representable.
- No arithmetic wrap: the pointer never exceeds count-1.

Test Plan:
1. Basic stream:
   - Stimulus: reset; start_i; writes addr0..3 data 0x0006,0x0011,0x0014,0x0008; done_i; rd_ready_i=1.
   - Response: four beats addr 0..3 with those data on consecutive cycles, rd_last_o on addr 3, drained_o pulse, count_o=4.
2. Backpressure:
   - Stimulus: same capture; rd_ready_i toggles 1,0,0,1,1,0,1.
   - Response: rd_data_o/rd_addr_o held during stalls, exactly 4 transfers, no duplicates or skips.
3. Out-of-order/overwrite:
   - Stimulus: writes addr2=0x00AA, addr0=0x0001, addr2=0x00BB, addr1=0x0002; done.
   - Response: count_o=3; stream 0x0001, 0x0002, 0x00BB.
4. Full and empty:
   - Stimulus: 64 writes addr0..63 data=addr*3.
   - Response: count_o=64, 64 beats, rd_last_o on addr 63.
   - Stimulus: start_i then done_i with no writes.
   - Response: no rd_valid_o, drained_o pulse, count_o=0.
5. Protocol errors:
   - Stimulus: writeZ_i during DRAIN; start_i during DRAIN.
   - Response: stream unaffected; err_o=1 and held until next start_i in IDLE clears it.
6. Reset mid-drain:
   - Stimulus: assert rst after 2 of 4 beats.
   - Response: all outputs 0 immediately (asynchronous), state IDLE; a fresh capture streams correctly from addr 0.
